pool_writeback: RTL and testbench
=================================

Name: pool_writeback

Overview:
- Sits directly downstream of the pooling stage. Consumes the COL per-column pooling results, which arrive skewed: column j is one cycle behind column j-1.
- Deskews the columns into whole output rows and buffers the rows in a small FIFO.
- Writes each row to the output feature-map memory over a valid/ready port, with sequential addresses from a programmed base.
- Sequences one layer: start, write cfg_rows rows, pulse done.

Parameters:
- DATA_W, 16, width of one pooled element.
- COL, 32, number of pooling columns; also the elements per row.
- ADDR_W, 10, width of the memory row address and of cfg_rows.
- FIFO_DEPTH, 4, capacity of the row FIFO in rows; must be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  layer start pulse; honoured only in IDLE.
- cfg_base_addr  in  ADDR_W  first row address; latched on accepted start.
- cfg_rows  in  ADDR_W  rows to write this layer; latched on accepted start.
- pool_data  in  DATA_W x [COL]  per-column pooling results.
- pool_valid  in  1 x [COL]  per-column result strobes, skewed one cycle per column.
- wr_valid  out  1  a row is presented to memory.
- wr_ready  in  1  memory accepts the row.
- wr_addr  out  ADDR_W  row address.
- wr_data  out  DATA_W x [COL]  row data; element j comes from column j.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the layer is complete.
- err_overflow  out  1  sticky; a row was dropped because the FIFO was full.
- err_skew  out  1  sticky; the aligned valid bits disagreed.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; FIFO emptied; all deskew valid bits cleared.
  - wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err_overflow=0, err_skew=0.
  - Reset mid-layer abandons the layer. Rows in flight are lost. No done pulse.
- Deskew:
  - Column j data and valid are delayed by COL-1-j cycles; column COL-1 is not delayed.
  - row_valid = delayed valid of column 0.
  - err_skew sets if, in any cycle, the aligned valid bits are neither all-0 nor all-1. The row is still processed using row_valid.
- Latency:
  - Column 0 strobe at cycle t → aligned at t+COL-1 → pushed at that edge.
  - wr_valid=1 from cycle t+COL when the FIFO was empty. Zero bubbles between consecutive rows.
- States:
  - IDLE: on start, latch cfg, clear rows_in, rows_out, err_overflow and err_skew.
    - cfg_rows≠0 → RUN.
    - cfg_rows==0 → DONE.
  - RUN: push rows; when rows_in reaches cfg_rows → DRAIN.
  - DRAIN: when the FIFO is empty and rows_out==cfg_rows → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start outside IDLE is ignored.
- Push rules:
  - Push when row_valid and state=RUN and rows_in<cfg_rows.
  - Rows arriving in IDLE, DRAIN or DONE, or beyond cfg_rows, are silently discarded.
  - If the FIFO is full and no pop occurs that cycle: drop the row, set err_overflow, do not increment rows_in.
  - Push and pop in the same cycle is legal, including when full.
- Output:
  - wr_valid = FIFO not empty. wr_data = FIFO head.
  - wr_addr = cfg_base_addr + rows_out, modulo 2^ADDR_W (wraps silently).
  - Pop and rows_out++ on wr_valid&&wr_ready.
  - While wr_valid&&!wr_ready, wr_addr and wr_data are held stable.
- Data passes through unmodified; no arithmetic on elements.
- Counters rows_in and rows_out are ADDR_W bits wide.

Decomposition:
- Package pool_pkg:
  - typedef elem_t (logic [DATA_W-1:0]).
  - typedef row_t (elem_t [COL]).
  - enum wb_state_t {IDLE, RUN, DRAIN, DONE}.
  - Default constants for DATA_W, COL, ADDR_W.
- Sub-module pool_deskew_line, instantiated once per column:
  - Parameterised delay line of DEPTH stages carrying {valid, data}.
  - DEPTH=0 is a wire.
  - Synchronous active-high clear of the valid bits.
- The FIFO and the FSM stay inline.

Test Plan:
- Single row: base=5, rows=1; column j strobes at cycle 10+j with data 100+j → wr_valid at cycle 10+COL, wr_addr=5, wr_data[j]=100+j; done pulses once when the FIFO is empty after the pop.
- Back-to-back: rows=8, one skewed row started every cycle, wr_ready=1 → 8 consecutive writes at addresses base..base+7, no gaps, done one cycle after DRAIN completes.
- Backpressure/overflow: rows=6, wr_ready=0, 6 rows pushed → first 4 buffered, rows 5–6 dropped, err_overflow=1; wr_addr/wr_data stable while stalled.
- Wrap/zero: base=1022, ADDR_W=10, rows=4 → addresses 1022, 1023, 0, 1. Separately, start with rows=0 → done within 2 cycles, no write.
- Skew error: column 7 strobe one cycle late → err_skew=1; start of the next layer clears it.
- Reset mid-layer: rst after 2 of 5 rows → next cycle wr_valid=0, busy=0, no done; a fresh start runs a full 5-row layer correctly.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and default sizing for the pooling write-back slice.
package pool_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_COL        = 32;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_DATA_W-1:0] elem_t;
  typedef elem_t [DEF_COL-1:0]   row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/pool_deskew_line.sv
// Fixed-length delay line carrying one column's {valid, data}.
// DEPTH=0 degenerates to a straight wire; only the valid bits are cleared.
module pool_deskew_line #(
  parameter int DEPTH  = 0,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Last column needs no delay; clock and reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0]             valid_reg;
      logic [DEPTH-1:0][DATA_W-1:0] data_reg;

      // Shift valid and data one stage per cycle; reset only drops the strobes.
      always_ff @(posedge clk) begin
        data_reg[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) data_reg[i] <= data_reg[i-1];
        if (rst) begin
          valid_reg <= '0;
        end else begin
          valid_reg[0] <= in_valid;
          for (int i = 1; i < DEPTH; i++) valid_reg[i] <= valid_reg[i-1];
        end
      end

      assign out_valid = valid_reg[DEPTH-1];
      assign out_data  = data_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pool_writeback.sv
// Deskews per-column pooling results into rows, buffers them in a small
// row FIFO and writes them to sequential memory rows for one layer.
// FIFO_DEPTH must be a power of two and at least 2.
module pool_writeback
  import pool_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int COL        = DEF_COL,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          cfg_base_addr,
  input  logic [ADDR_W-1:0]          cfg_rows,
  input  logic [COL-1:0][DATA_W-1:0] pool_data,
  input  logic [COL-1:0]             pool_valid,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [COL-1:0][DATA_W-1:0] wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overflow,
  output logic                       err_skew
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Aligned column outputs: column gi is delayed COL-1-gi cycles.
  logic [COL-1:0]             al_valid;
  logic [COL-1:0][DATA_W-1:0] al_data;

  for (genvar gi = 0; gi < COL; gi++) begin : g_col
    pool_deskew_line #(
      .DEPTH  (COL - 1 - gi),
      .DATA_W (DATA_W)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pool_valid[gi]),
      .in_data   (pool_data[gi]),
      .out_valid (al_valid[gi]),
      .out_data  (al_data[gi])
    );
  end

  wb_state_t                  state_reg;
  logic [PTR_W:0]             wptr_reg, rptr_reg;
  logic [ADDR_W-1:0]          rows_in_reg, rows_out_reg;
  logic [ADDR_W-1:0]          base_reg, cfg_rows_reg;
  logic                       busy_reg, done_reg, err_overflow_reg, err_skew_reg;
  logic [COL-1:0][DATA_W-1:0] mem [FIFO_DEPTH];

  logic row_valid, skew_seen, fifo_empty, fifo_full;
  logic pop, push_req, push, drop;

  // Column 0 decides whether a row exists; disagreement only raises the flag.
  assign row_valid  = al_valid[0];
  assign skew_seen  = (al_valid != '0) && (al_valid != '1);
  assign fifo_empty = (wptr_reg == rptr_reg);
  assign fifo_full  = ((wptr_reg ^ rptr_reg) == {1'b1, {PTR_W{1'b0}}});
  assign pop        = !fifo_empty && wr_ready;
  assign push_req   = row_valid && (state_reg == RUN) && (rows_in_reg < cfg_rows_reg);
  // A same-cycle pop frees a slot, so a full FIFO can still accept the row.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // Row storage; head is read from the slot the read pointer names.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg[PTR_W-1:0]] <= al_data;
  end

  assign wr_valid     = !fifo_empty;
  assign wr_data      = fifo_empty ? '0 : mem[rptr_reg[PTR_W-1:0]];
  assign wr_addr      = base_reg + rows_out_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err_overflow = err_overflow_reg;
  assign err_skew     = err_skew_reg;

  // Layer sequencer, FIFO pointers, row counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      rows_in_reg      <= '0;
      rows_out_reg     <= '0;
      base_reg         <= '0;
      cfg_rows_reg     <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_overflow_reg <= 1'b0;
      err_skew_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (push) begin
        wptr_reg    <= wptr_reg + (PTR_W+1)'(1);
        rows_in_reg <= rows_in_reg + ADDR_W'(1);
      end
      if (pop) begin
        rptr_reg     <= rptr_reg + (PTR_W+1)'(1);
        rows_out_reg <= rows_out_reg + ADDR_W'(1);
      end
      if (drop)      err_overflow_reg <= 1'b1;
      if (skew_seen) err_skew_reg     <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg         <= cfg_base_addr;
            cfg_rows_reg     <= cfg_rows;
            rows_in_reg      <= '0;
            rows_out_reg     <= '0;
            err_overflow_reg <= 1'b0;
            err_skew_reg     <= 1'b0;
            busy_reg         <= 1'b1;
            if (cfg_rows == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (rows_in_reg == cfg_rows_reg) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && (rows_out_reg == cfg_rows_reg)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_writeback.sv
// Randomised bench for pool_writeback with a queue-based reference model
// and a scoreboard monitor that checks every memory write.
`timescale 1ns/1ps
module tb_pool_writeback;
  import pool_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int NC = DEF_COL;
  localparam int AW = DEF_ADDR_W;
  localparam int FD = DEF_FIFO_DEPTH;

  typedef row_t bus_t;
  typedef struct {int cyc; bus_t data; bit skew;} arr_t;
  typedef struct {logic [AW-1:0] addr; bus_t data;} wr_t;

  logic          clk = 1'b0;
  logic          rst, start, wr_valid, wr_ready, busy, done, err_overflow, err_skew;
  logic [AW-1:0] cfg_base_addr, cfg_rows, wr_addr;
  bus_t          pool_data, wr_data;
  logic [NC-1:0] pool_valid;

  always #5 clk = ~clk;

  pool_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_rows      (cfg_rows),
    .pool_data     (pool_data),
    .pool_valid    (pool_valid),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .err_overflow  (err_overflow),
    .err_skew      (err_skew)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int first_wr_cyc = -1, last_wr_cyc = 0, n_wr = 0, done_exp_cyc = -1, ready_mode = 0;

  // Reference model state: rows in flight, expected writes, layer counters.
  int   m_base = 0, m_rows = 0, m_in = 0, m_out = 0, m_occ = 0;
  bit   m_ovf = 0, m_skew = 0;
  arr_t arr_q[$];
  wr_t  exp_q[$];

  // Per-cycle strobe schedule for the skewed columns.
  logic [NC-1:0] sch_v [int];
  bus_t          sch_d [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_row(input string nm, input bus_t act, input bus_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bus_t rand_row();
    bus_t r;
    for (int j = 0; j < NC; j++) r[j] = DW'($urandom);
    return r;
  endfunction

  // Schedule one row: column j strobes at t+j (late column one cycle later).
  task automatic issue_row(input int t, input bus_t d, input int late);
    arr_t          a;
    logic [NC-1:0] v;
    bus_t          dd;
    a.data = d;
    for (int j = 0; j < NC; j++) begin
      int c;
      c = t + j + ((j == late) ? 1 : 0);
      if (!sch_v.exists(c)) begin
        sch_v[c] = '0;
        sch_d[c] = '0;
      end
      v = sch_v[c]; v[j] = 1'b1; sch_v[c] = v;
      dd = sch_d[c]; dd[j] = d[j]; sch_d[c] = dd;
    end
    // The late column is not present when column 0's row is assembled.
    if (late >= 0) a.data[late] = '0;
    a.cyc  = t + NC - 1;
    a.skew = (late >= 0);
    arr_q.push_back(a);
  endtask

  // Input driver: column strobes from the schedule and the wr_ready pattern.
  initial begin
    pool_valid = '0;
    pool_data  = '0;
    wr_ready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (sch_v.exists(cyc)) begin
        pool_valid = sch_v[cyc];
        pool_data  = sch_d[cyc];
        sch_v.delete(cyc);
        sch_d.delete(cyc);
      end else begin
        pool_valid = '0;
        pool_data  = '0;
      end
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = 1'b0;
        default: wr_ready = ($urandom_range(99, 0) < 60);
      endcase
    end
  end

  // Reference model: a row becomes available COL-1 cycles after its column 0
  // strobe; it is kept if the layer still wants rows and the buffer has room.
  initial begin : model
    bit   pop, arrive;
    arr_t a;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_rows = 0; m_in = 0; m_out = 0; m_occ = 0; m_ovf = 0; m_skew = 0;
        arr_q.delete();
        exp_q.delete();
        done_exp_cyc = -1;
      end else begin
        pop    = (m_occ > 0) && wr_ready;
        arrive = 1'b0;
        if (arr_q.size() > 0 && arr_q[0].cyc == cyc) begin
          a      = arr_q.pop_front();
          arrive = 1'b1;
        end
        if (arrive) begin
          if (a.skew) m_skew = 1'b1;
          if (m_in < m_rows) begin
            if (m_occ < FD || pop) begin
              w.addr = AW'((m_base + m_in) % (1 << AW));
              w.data = a.data;
              exp_q.push_back(w);
              m_in++;
              m_occ++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
        if (pop) begin
          m_occ--;
          m_out++;
          if (m_out == m_rows) done_exp_cyc = cyc + 2;
        end
        if (start) begin
          m_base = int'(cfg_base_addr);
          m_rows = int'(cfg_rows);
          m_in = 0; m_out = 0; m_ovf = 0; m_skew = 0;
          if (m_rows == 0) done_exp_cyc = cyc + 1;
        end
      end
    end
  end

  // Monitor: scoreboard every accepted write, hold-while-stalled, done timing.
  initial begin : monitor
    bit            stalled;
    logic [AW-1:0] h_addr;
    bus_t          h_data;
    wr_t           e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("stall_valid", wr_valid, 1);
        chk("stall_addr", wr_addr, h_addr);
        chk_row("stall_data", wr_data, h_data);
      end
      if (wr_valid && wr_ready) begin
        n_wr++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", wr_addr, 'x);
        end else begin
          e = exp_q.pop_front();
          $display("WR cycle=%0d addr=%0d", cyc, wr_addr);
          chk("wr_addr", wr_addr, e.addr);
          chk_row("wr_data", wr_data, e.data);
        end
      end
      stalled = wr_valid && !wr_ready;
      h_addr  = wr_addr;
      h_data  = wr_data;
      if (done) begin
        if (done_exp_cyc < 0) chk("unexpected_done_cycle", cyc, 'x);
        else chk("done_cycle", cyc, done_exp_cyc);
        done_exp_cyc = -1;
      end
    end
  end

  task automatic start_layer(input int base, input int rows);
    @(posedge clk); #1;
    start         = 1'b1;
    cfg_base_addr = AW'(base);
    cfg_rows      = AW'(rows);
    first_wr_cyc  = -1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("errs_cleared_on_start", {err_overflow, err_skew}, 0);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < limit);
    chk("done_seen", done, 1);
  endtask

  task automatic end_checks();
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_skew", err_skew, m_skew);
    chk("writes_drained", exp_q.size(), 0);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  // Keep feeding rows until the model has accepted the whole layer.
  task automatic run_layer(input int base, input int rows, input int mode,
                           input int maxgap, input int late);
    int guard;
    guard      = 0;
    ready_mode = mode;
    start_layer(base, rows);
    while (m_in < m_rows && guard < 3000) begin
      if (arr_q.size() < m_rows - m_in) begin
        issue_row(cyc + 1, rand_row(), late);
        late = -1;
      end
      @(posedge clk); #1;
      guard++;
      repeat ($urandom_range(maxgap, 0)) begin
        @(posedge clk); #1;
      end
    end
    wait_done(400);
    end_checks();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   t, w0;
    bus_t r0, d;
    rst = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_rows = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flags", {wr_valid, busy, done, err_overflow, err_skew}, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk_row("rst_wr_data", wr_data, '0);

    // Single row with the documented strobe pattern.
    ready_mode = 0;
    start_layer(5, 1);
    t = cyc + 10;
    for (int j = 0; j < NC; j++) d[j] = DW'(100 + j);
    issue_row(t, d, -1);
    wait_done(300);
    chk("single_latency", first_wr_cyc, t + NC);
    end_checks();

    // Back-to-back rows, always ready: no gaps between writes.
    start_layer($urandom_range(0, 1000), 8);
    t = cyc + 2;
    for (int i = 0; i < 8; i++) issue_row(t + i, rand_row(), -1);
    wait_done(300);
    chk("b2b_first", first_wr_cyc, t + NC);
    chk("b2b_span", last_wr_cyc - first_wr_cyc, 7);
    end_checks();

    // Backpressure: buffer fills, extra rows dropped, head held stable.
    ready_mode = 1;
    start_layer(200, 6);
    t  = cyc + 2;
    r0 = rand_row();
    issue_row(t, r0, -1);
    for (int i = 1; i < 6; i++) issue_row(t + i, rand_row(), -1);
    while (cyc < t + 5 + NC + 2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_valid", wr_valid, 1);
    chk("ovf_addr", wr_addr, 200);
    chk_row("ovf_head", wr_data, r0);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    issue_row(cyc + 1, rand_row(), -1);
    issue_row(cyc + 2, rand_row(), -1);
    wait_done(300);
    end_checks();

    // Address wrap, random backpressure.
    run_layer(1022, 4, 2, 2, -1);

    // Empty layer completes immediately with no write.
    w0 = n_wr;
    start_layer(77, 0);
    wait_done(2);
    end_checks();
    chk("zero_rows_no_write", n_wr - w0, 0);

    // Column 7 strobes late; the next start must clear the flag.
    run_layer(300, 1, 0, 0, 7);
    run_layer(400, 3, 2, 1, -1);

    // Reset in the middle of a 5-row layer.
    ready_mode = 0;
    start_layer(50, 5);
    t = cyc + 2;
    for (int i = 0; i < 5; i++) issue_row(t + 3 * i, rand_row(), -1);
    w0 = n_wr;
    t  = 0;
    while (n_wr < w0 + 2 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("mid_layer_writes", n_wr - w0, 2);
    #1;
    rst = 1'b1;
    sch_v.delete();
    sch_d.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", wr_valid, 0);
    chk("post_rst_busy", busy, 0);
    repeat (40) @(negedge clk);
    run_layer(50, 5, 2, 1, -1);

    // Randomised layers.
    for (int k = 0; k < 4; k++)
      run_layer($urandom_range(0, 1023), $urandom_range(1, 12), 2, $urandom_range(0, 3), -1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
